// File: rtl/tx_serial_pkg.sv
// Shared types and line levels for the framed serial transmitter.
package tx_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Divides the clock into serial bit periods; tick marks the last cycle of each bit.
module bit_timer
  import tx_serial_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = cnt_width(DIV);

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tx_serial4b.sv
// Parallel-in, serial-out transmitter: start bit, WIDTH data bits LSB-first, stop bit.
module tx_serial4b
  import tx_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             tx,
  output logic             busy
);

  localparam int unsigned BW = cnt_width(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BW-1:0]    bit_cnt;
  logic             tick;
  logic             timer_clear;

  // Holding the timer clear while idle makes every frame start from div_cnt = 0.
  assign timer_clear = (state == IDLE);
  assign shreg_nxt   = shreg >> 1;
  assign busy        = ~ready;

  bit_timer #(
    .DIV(DIV)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(timer_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx      <= LINE_IDLE;
      ready   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid) begin
            shreg   <= data_in;
            bit_cnt <= '0;
            state   <= START;
            tx      <= START_BIT;
            ready   <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= shreg_nxt;
            if (bit_cnt == BW'(WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= STOP;
              tx      <= STOP_BIT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg_nxt[0];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            tx    <= LINE_IDLE;
            ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_serial4b.sv
// Scoreboard bench: accepted words queue an expected frame; a line monitor checks each frame.
module tb_tx_serial4b;

  typedef struct {
    int         inst;
    logic [3:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] vld;
  logic [1:0] rdy;
  logic [1:0] txl;
  logic [1:0] bsy;
  logic [3:0] din [2];

  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          acc      [2];
  int          acc_cyc  [2];
  logic [63:0] line     [2];
  int          len      [2];
  bit          infr     [2];

  always #5 clk = ~clk;

  tx_serial4b #(.WIDTH(4), .DIV(4)) dut4 (
    .clk    (clk),
    .reset  (reset),
    .data_in(din[0]),
    .valid  (vld[0]),
    .ready  (rdy[0]),
    .tx     (txl[0]),
    .busy   (bsy[0])
  );

  tx_serial4b #(.WIDTH(4), .DIV(1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .data_in(din[1]),
    .valid  (vld[1]),
    .ready  (rdy[1]),
    .tx     (txl[1]),
    .busy   (bsy[1])
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected line level per cycle: start slot, data slots LSB first, stop slot.
  function automatic logic [63:0] frame_line(logic [3:0] d, int div);
    logic [63:0] l = '0;
    for (int k = 0; k < 6 * div; k++) begin
      int s = k / div;
      l[k] = (s == 0) ? 1'b0 : (s <= 4) ? d[s-1] : 1'b1;
    end
    return l;
  endfunction

  // Acceptance logger: pushes the expected frame for every accepted word.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (vld[i] && rdy[i]) begin
          exp_q.push_back('{inst: i, data: din[i]});
          acc[i]++;
          acc_cyc[i] = cyc;
        end
      end
    end
    cyc++;
  end

  // Line monitor: collects tx while busy, checks the whole frame when ready returns.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        infr[i] = 1'b0;
        len[i]  = 0;
      end else if (!rdy[i]) begin
        if (len[i] == 0) line[i] = '0;
        if (len[i] < 64) line[i][len[i]] = txl[i];
        len[i]++;
        infr[i] = 1'b1;
        check("busy_is_not_ready", bsy[i], 1'b1);
      end else begin
        check("idle_tx_high", txl[i], 1'b1);
        if (infr[i]) begin
          exp_t e;
          int   dv;
          infr[i] = 1'b0;
          dv = (i == 0) ? 4 : 1;
          check("frame_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_inst", e.inst, i);
            check("frame_len", len[i], 6 * dv);
            check("frame_line", line[i], frame_line(e.data, dv));
          end
          len[i] = 0;
        end
      end
    end
  end

  task automatic wait_idle(int i);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rdy[i]) return;
    end
    check("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic go(int i, logic [3:0] d);
    @(posedge clk);
    #1;
    vld[i] = 1'b1;
    din[i] = d;
    @(posedge clk);
    #1;
    vld[i] = 1'b0;
  endtask

  task automatic low_count(int i, output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rdy[i]) return;
      n++;
    end
  endtask

  task automatic reset_mid_frame(logic [3:0] d, logic tx_before);
    go(0, d);
    repeat (9) @(posedge clk);
    #1;
    check("pre_reset_tx", txl[0], tx_before);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_tx", txl[0], 1'b1);
    check("async_reset_ready", rdy[0], 1'b1);
    check("async_reset_busy", bsy[0], 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int a0;
    int c0;
    reset  = 1'b1;
    vld    = '0;
    din[0] = '0;
    din[1] = '0;
    acc    = '{0, 0};
    #1;
    check("reset_tx", txl[0], 1'b1);
    check("reset_ready", rdy[0], 1'b1);
    check("reset_busy", bsy[0], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single frame 1011.
    wait_idle(0);
    go(0, 4'b1011);
    low_count(0, n);
    check("ready_low_1011", n, 24);

    // Words offered while busy are ignored.
    wait_idle(0);
    @(posedge clk);
    #1;
    vld[0] = 1'b1;
    din[0] = 4'h3;
    @(posedge clk);
    #1;
    din[0] = 4'hC;
    a0 = acc[0];
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rdy[0]) break;
    end
    vld[0] = 1'b0;
    check("no_reaccept_busy", acc[0] - a0, 0);

    // Back-to-back with valid held high.
    wait_idle(0);
    a0 = acc[0];
    @(posedge clk);
    #1;
    vld[0] = 1'b1;
    din[0] = 4'hA;
    @(posedge clk);
    #1;
    c0 = acc_cyc[0];
    din[0] = 4'h5;
    @(negedge clk);
    check("b2b_start1", txl[0], 1'b0);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (acc[0] == a0 + 2) break;
    end
    vld[0] = 1'b0;
    check("b2b_accepts", acc[0] - a0, 2);
    check("b2b_period", acc_cyc[0] - c0, 25);
    @(negedge clk);
    check("b2b_start2", txl[0], 1'b0);

    // Reset mid-frame, then a clean frame.
    wait_idle(0);
    reset_mid_frame(4'h0, 1'b0);
    wait_idle(0);
    reset_mid_frame(4'hF, 1'b1);
    wait_idle(0);
    go(0, 4'h0);
    low_count(0, n);
    check("ready_low_after_reset", n, 24);

    // DIV = 1 instance.
    wait_idle(1);
    go(1, 4'b0110);
    low_count(1, n);
    check("ready_low_div1", n, 6);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
